perceptron_bp: RTL and testbench

- Backpropagation update unit for one perceptron; the backward pass paired with the forward perceptron.
- Accepts the forward-pass activation, inputs, weights and bias, plus the error term.
- Computes the delta and the updated weights/bias, then issues a one-cycle write strobe to the perceptron weight store.
- Also emits the per-input back-propagated error terms for the previous layer.
- All arithmetic uses one shared fixed-point multiplier, sequenced by a state machine.

---
 rtl/perceptron_bp_pkg.sv | 38 +++
 rtl/perceptron_bp_fxp_mul.sv | 30 +++
 rtl/perceptron_bp.sv | 173 +++++++++++++++++
 tb/tb_perceptron_bp.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_bp_pkg.sv
// Shared constants, state encoding and saturating arithmetic for the perceptron
// backpropagation unit.
package perceptron_bp_pkg;

  localparam int          FXP_FRAC = 24;
  localparam logic [31:0] FXP_ONE  = 32'h0100_0000;

  typedef enum logic [2:0] {
    IDLE,
    DERIV,
    DELTA,
    SCALE,
    UPD_W,
    UPD_BK,
    BIAS,
    WRITE
  } state_t;

  // Operands arrive sign-extended to 64 bits.
  // The result is clamped to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_addsub(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input logic               sub,
    input int                 w
  );
    logic signed [63:0] s;
    logic signed [63:0] maxv;
    logic signed [63:0] minv;
    s    = sub ? (a - b) : (a + b);
    maxv = (64'sd1 <<< (w - 1)) - 64'sd1;
    minv = -(64'sd1 <<< (w - 1));
    if (s > maxv) return maxv;
    if (s < minv) return minv;
    return s;
  endfunction

endpackage

// File: rtl/perceptron_bp_fxp_mul.sv
// Signed fixed-point multiply: full product, drop FRAC fraction bits (floor),
// saturate to the WIDTH-bit signed range.
module fxp_mul #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] shifted;
  logic [WIDTH:0]            hi;
  logic                      ovf;

  always_comb begin
    prod    = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    shifted = prod >>> FRAC;
    hi      = shifted[2*WIDTH-1:WIDTH-1];
    // Result fits only if every bit above the sign is a copy of it.
    ovf     = !((&hi) || (~|hi));
    if (ovf) begin
      p = prod[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      p = shifted[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/perceptron_bp.sv
// Backward pass for one perceptron: delta, weight/bias update and back-propagated
// error, all sequenced through a single shared fixed-point multiplier.
//
//   state  | meaning
//   IDLE   | waiting for i_start; latches inputs and error term
//   DERIV  | d = a * (1 - a)
//   DELTA  | delta = err * d
//   SCALE  | lrd = LR * delta, index cleared
//   UPD_W  | w_new[i] = w[i] - lrd * k[i]
//   UPD_BK | back[i] = delta * w_old[i], advance index or finish
//   BIAS   | b_new = b - lrd, results moved to output registers
//   WRITE  | one-cycle write strobe / done pulse
module perceptron_bp
  import perceptron_bp_pkg::*;
#(
  parameter int               NUM       = 2,
  parameter int               WIDTH     = 32,
  parameter int               FRAC      = FXP_FRAC,
  parameter logic [WIDTH-1:0] LR        = WIDTH'(FXP_ONE >> 1),
  parameter int               OUT_LAYER = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [NUM*WIDTH-1:0] i_k,
  input  logic [NUM*WIDTH-1:0] i_w,
  input  logic [WIDTH-1:0]     i_b,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_t,
  input  logic [WIDTH-1:0]     i_e,
  output logic [NUM*WIDTH-1:0] o_w,
  output logic [WIDTH-1:0]     o_b,
  output logic                 o_wr,
  output logic [WIDTH-1:0]     o_delta,
  output logic [NUM*WIDTH-1:0] o_back,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int               IW   = $clog2(NUM) + 1;
  localparam logic [IW-1:0]    LAST = IW'(NUM - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(64'd1 << FRAC);

  function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    return WIDTH'(sat_addsub(64'(signed'(x)), 64'(signed'(y)), 1'b1, WIDTH));
  endfunction

  state_t state, state_n;

  logic [IW-1:0]        idx;
  logic [NUM*WIDTH-1:0] k_r, w_r, wn_r, bk_r, ow_r, oback_r;
  logic [WIDTH-1:0]     b_r, a_r, err_r, d_r, delta_r, lrd_r, ob_r;
  logic [WIDTH-1:0]     k_sel, w_sel;
  logic signed [WIDTH-1:0] mul_a, mul_b, mul_p;

  fxp_mul #(
    .WIDTH(WIDTH),
    .FRAC (FRAC)
  ) u_mul (
    .a(mul_a),
    .b(mul_b),
    .p(mul_p)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (i_start) state_n = DERIV;
      DERIV:   state_n = DELTA;
      DELTA:   state_n = SCALE;
      SCALE:   state_n = UPD_W;
      UPD_W:   state_n = UPD_BK;
      UPD_BK:  state_n = (idx == LAST) ? BIAS : UPD_W;
      BIAS:    state_n = WRITE;
      WRITE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    k_sel = '0;
    w_sel = '0;
    for (int j = 0; j < NUM; j++) begin
      if (idx == IW'(j)) begin
        k_sel = k_r[j*WIDTH +: WIDTH];
        w_sel = w_r[j*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      DERIV:  begin mul_a = a_r;     mul_b = sat_sub(ONE, a_r); end
      DELTA:  begin mul_a = err_r;   mul_b = d_r;               end
      SCALE:  begin mul_a = LR;      mul_b = delta_r;           end
      UPD_W:  begin mul_a = lrd_r;   mul_b = k_sel;             end
      UPD_BK: begin mul_a = delta_r; mul_b = w_sel;             end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx     <= '0;
      k_r     <= '0;
      w_r     <= '0;
      wn_r    <= '0;
      bk_r    <= '0;
      ow_r    <= '0;
      oback_r <= '0;
      b_r     <= '0;
      a_r     <= '0;
      err_r   <= '0;
      d_r     <= '0;
      delta_r <= '0;
      lrd_r   <= '0;
      ob_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            k_r   <= i_k;
            w_r   <= i_w;
            b_r   <= i_b;
            a_r   <= i_a;
            err_r <= (OUT_LAYER != 0) ? sat_sub(i_a, i_t) : i_e;
          end
        end
        DERIV: d_r <= mul_p;
        DELTA: delta_r <= mul_p;
        SCALE: begin
          lrd_r <= mul_p;
          idx   <= '0;
        end
        UPD_W: begin
          for (int j = 0; j < NUM; j++) begin
            if (idx == IW'(j)) wn_r[j*WIDTH +: WIDTH] <= sat_sub(w_sel, mul_p);
          end
        end
        UPD_BK: begin
          for (int j = 0; j < NUM; j++) begin
            if (idx == IW'(j)) bk_r[j*WIDTH +: WIDTH] <= mul_p;
          end
          if (idx != LAST) idx <= idx + IW'(1);
        end
        BIAS: begin
          // Outputs change only here so they hold steady between writes.
          ob_r    <= sat_sub(b_r, lrd_r);
          ow_r    <= wn_r;
          oback_r <= bk_r;
        end
        default: ;
      endcase
    end
  end

  assign o_w     = ow_r;
  assign o_b     = ob_r;
  assign o_back  = oback_r;
  assign o_delta = delta_r;
  assign o_busy  = (state != IDLE);
  assign o_wr    = (state == WRITE);
  assign o_done  = (state == WRITE);

endmodule

// File: tb/tb_perceptron_bp.sv
// Self-checking bench: an output-layer and a hidden-layer instance run side by
// side against an arithmetic reference model of the update rules.
module tb_perceptron_bp;

  localparam int     NUM     = 2;
  localparam int     LAT     = 2*NUM + 4;
  localparam int     PERIOD  = 2*NUM + 6;  // IDLE + DERIV..BIAS + WRITE
  localparam longint ONE     = 64'sd16777216;
  localparam longint LR      = 64'sd8388608;
  localparam longint MAXV    = 64'sd2147483647;
  localparam longint MINV    = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [63:0] i_k = '0, i_w = '0;
  logic [31:0] i_b = '0, i_a = '0, i_t = '0, i_e = '0;

  logic [63:0] w1, back1, w0, back0;
  logic [31:0] b1, delta1, b0, delta0;
  logic        wr1, busy1, done1, wr0, busy0, done0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  perceptron_bp #(.NUM(NUM), .OUT_LAYER(1)) dut1 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_k(i_k), .i_w(i_w), .i_b(i_b),
    .i_a(i_a), .i_t(i_t), .i_e(i_e), .o_w(w1), .o_b(b1), .o_wr(wr1),
    .o_delta(delta1), .o_back(back1), .o_busy(busy1), .o_done(done1)
  );

  perceptron_bp #(.NUM(NUM), .OUT_LAYER(0)) dut0 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_k(i_k), .i_w(i_w), .i_b(i_b),
    .i_a(i_a), .i_t(i_t), .i_e(i_e), .o_w(w0), .o_b(b0), .o_wr(wr0),
    .o_delta(delta0), .o_back(back0), .o_busy(busy0), .o_done(done0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] v);
    return longint'(signed'(v));
  endfunction

  function automatic longint sat(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic longint fmul(input longint x, input longint y);
    longint p;
    p = x * y;
    return sat(p >>> 24);
  endfunction

  task automatic model(input bit ol, input logic [31:0] a, t, e, b,
                       input logic [63:0] k, w,
                       output logic [31:0] xdelta, xb,
                       output logic [63:0] xw, xback);
    longint err, d, dl, lrd;
    err = ol ? sat(sx(a) - sx(t)) : sx(e);
    d   = fmul(sx(a), sat(ONE - sx(a)));
    dl  = fmul(err, d);
    lrd = fmul(LR, dl);
    for (int i = 0; i < NUM; i++) begin
      xw[i*32 +: 32]    = 32'(sat(sx(w[i*32 +: 32]) - fmul(lrd, sx(k[i*32 +: 32]))));
      xback[i*32 +: 32] = 32'(fmul(dl, sx(w[i*32 +: 32])));
    end
    xdelta = 32'(dl);
    xb     = 32'(sat(sx(b) - lrd));
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, t, e, b,
                        input logic [63:0] k, w);
    logic [31:0] d1, bb1, d0, bb0;
    logic [63:0] ww1, bk1, ww0, bk0;
    int lat;
    model(1'b1, a, t, e, b, k, w, d1, bb1, ww1, bk1);
    model(1'b0, a, t, e, b, k, w, d0, bb0, ww0, bk0);
    @(negedge clk);
    i_a = a; i_t = t; i_e = e; i_b = b; i_k = k; i_w = w; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    // Inputs must already be latched, so disturb them.
    i_a = $urandom; i_t = $urandom; i_e = $urandom; i_b = $urandom;
    i_k = {$urandom, $urandom}; i_w = {$urandom, $urandom};
    lat = 0;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      @(negedge clk);
      if (wr1) lat = c;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(LAT));
    if (lat != 0) begin
      chk({tag, ".wr0"}, 64'(wr0), 64'd1);
      chk({tag, ".done"}, 64'({done1, done0}), 64'd3);
      chk({tag, ".busy"}, 64'({busy1, busy0}), 64'd3);
      chk({tag, ".delta1"}, 64'(delta1), 64'(d1));
      chk({tag, ".w1"}, w1, ww1);
      chk({tag, ".b1"}, 64'(b1), 64'(bb1));
      chk({tag, ".back1"}, back1, bk1);
      chk({tag, ".delta0"}, 64'(delta0), 64'(d0));
      chk({tag, ".w0"}, w0, ww0);
      chk({tag, ".b0"}, 64'(b0), 64'(bb0));
      chk({tag, ".back0"}, back0, bk0);
      @(negedge clk);
      chk({tag, ".wr_after"}, 64'({wr1, wr0, done1, done0}), 64'd0);
      chk({tag, ".busy_after"}, 64'({busy1, busy0}), 64'd0);
      chk({tag, ".w1_hold"}, w1, ww1);
      chk({tag, ".b1_hold"}, 64'(b1), 64'(bb1));
    end
  endtask

  function automatic logic [31:0] rnd_small();
    return $urandom_range(0, 32'h03FF_FFFF) - 32'h0200_0000;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, idles, first, last, seen;
    repeat (3) @(negedge clk);
    chk("reset.out", {31'd0, busy1, wr1, done1, w1[31:0] | back1[31:0] | {b1 | delta1}},
        64'd0);
    chk("reset.hi", w1 | back1 | w0 | back0, 64'd0);
    rst = 1'b1;

    run_op("nominal", 32'h0080_0000, 32'h0, 32'h0,
           32'h0, {32'h0080_0000, 32'h0100_0000}, {32'hFFC0_0000, 32'h0040_0000});
    chk("nominal.delta_abs", 64'(delta1), 64'h0020_0000);
    chk("nominal.w_abs", w1, {32'hFFB8_0000, 32'h0030_0000});
    chk("nominal.b_abs", 64'(b1), 64'hFFF0_0000);
    chk("nominal.back_abs", back1, {32'hFFF8_0000, 32'h0008_0000});

    run_op("saturate", 32'h0080_0000, 32'h0, 32'h7FFF_FFFF, 32'h0,
           {32'h0, 32'h7FFF_FFFF}, {32'h0, 32'h8000_0000});
    chk("saturate.w0_clamp", 64'(w0[31:0]), 64'h8000_0000);

    run_op("zero_grad", 32'h0080_0000, 32'h0080_0000, 32'h0, 32'h1234_5678,
           {32'h0111_0000, 32'hFF00_0000}, {32'h0222_0000, 32'hFE00_0000});
    chk("zero_grad.w_same", w1, {32'h0222_0000, 32'hFE00_0000});
    chk("zero_grad.b_same", 64'(b1), 64'h1234_5678);

    run_op("a_one", 32'h0100_0000, 32'h0, 32'h4000_0000, 32'h0055_0000,
           {32'h0300_0000, 32'hFD00_0000}, {32'h0010_0000, 32'h0020_0000});
    chk("a_one.delta", 64'({delta1, delta0}), 64'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    i_a = 32'h0040_0000; i_t = 32'h00C0_0000; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    seen = 0;
    repeat (3) begin @(negedge clk); if (wr1 || wr0) seen++; end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midreset.busy", 64'({busy1, busy0}), 64'd0);
    chk("midreset.outs", w1 | back1 | w0 | back0 | {b1, delta1} | {b0, delta0}, 64'd0);
    repeat (12) begin @(negedge clk); if (wr1 || wr0) seen++; end
    chk("midreset.no_wr", 64'(seen), 64'd0);

    run_op("after_reset", 32'h0080_0000, 32'h0, 32'h0,
           32'h0, {32'h0080_0000, 32'h0100_0000}, {32'hFFC0_0000, 32'h0040_0000});

    // Start held high continuously.
    @(negedge clk);
    i_start = 1'b1;
    pulses = 0; idles = 0; first = -1; last = -1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (!busy1) idles++;
      if (wr1) begin
        if (first < 0) first = c;
        else chk("b2b.spacing", 64'(c - last), 64'(PERIOD));
        last = c;
        pulses++;
      end
    end
    i_start = 1'b0;
    chk("b2b.first", 64'(first), 64'(LAT));
    chk("b2b.pulses", 64'(pulses), 64'd4);
    chk("b2b.idles", 64'(idles), 64'd4);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (!busy1 && !busy0) seen = 1;
    end
    chk("b2b.drain", 64'(seen), 64'd1);

    for (int n = 0; n < 30; n++) begin
      logic [31:0] a, t, e, b;
      logic [63:0] k, w;
      a = $urandom_range(0, 32'h0100_0000);
      t = $urandom_range(0, 32'h0100_0000);
      e = (n % 3 == 0) ? $urandom : rnd_small();
      b = (n % 4 == 0) ? $urandom : rnd_small();
      k = (n % 5 == 0) ? {$urandom, $urandom} : {rnd_small(), rnd_small()};
      w = (n % 6 == 0) ? {$urandom, $urandom} : {rnd_small(), rnd_small()};
      run_op($sformatf("rand%0d", n), a, t, e, b, k, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
